// File: rtl/video_pkg.sv
// Shared video constants, host register map and foreground pixel layout.
package video_pkg;

    localparam int HRES = 640;
    localparam int VRES = 480;

    localparam logic [10:0] ADDR_POS_X = 11'h400;
    localparam logic [10:0] ADDR_POS_Y = 11'h401;
    localparam logic [10:0] ADDR_CTRL  = 11'h402;

    localparam int PIXEL_W   = 15;
    localparam int ALPHA_W   = 3;
    localparam int COLOR_W   = 4;
    localparam int ALPHA_LSB = 12;
    localparam int R_LSB     = 8;
    localparam int G_LSB     = 4;
    localparam int B_LSB     = 0;

    typedef struct packed {
        logic [ALPHA_W-1:0] alpha;
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } pixel_t;

    function automatic pixel_t unpack_pixel(input logic [PIXEL_W-1:0] w);
        pixel_t p;
        p.alpha = w[ALPHA_LSB +: ALPHA_W];
        p.r     = w[R_LSB +: COLOR_W];
        p.g     = w[G_LSB +: COLOR_W];
        p.b     = w[B_LSB +: COLOR_W];
        return p;
    endfunction

endpackage

// File: rtl/sprite_ram.sv
// Sprite pixel store: one write port, one registered read port, read-first.
module sprite_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int W     = 15
) (
    input  logic          clk_i,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Contents are not reset so the array maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sprite_layer.sv
// Single hardware sprite overlaid on the raster; two-cycle pipeline with
// frame-synchronous commit of position/enable registers.
module sprite_layer
    import video_pkg::*;
#(
    parameter int HSZ               = 10,
    parameter int VSZ               = 9,
    parameter int SIZE              = 16,
    parameter int BLANK_WRITES_ONLY = 1
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    input  logic [HSZ-1:0] hcount_i,
    input  logic [VSZ-1:0] vcount_i,
    input  logic           de_i,
    input  logic           hsync_i,
    input  logic           vsync_i,
    input  logic           wr_valid_i,
    output logic           wr_ready_o,
    input  logic [10:0]    wr_addr_i,
    input  logic [14:0]    wr_data_i,
    output logic [3:0]     fg_r_o,
    output logic [3:0]     fg_g_o,
    output logic [3:0]     fg_b_o,
    output logic [2:0]     fg_alpha_o,
    output logic           de_o,
    output logic           hsync_o,
    output logic           vsync_o,
    output logic           frame_commit_o
);

    localparam int NPIX = SIZE * SIZE;
    localparam int AW   = $clog2(NPIX);
    localparam int LW   = $clog2(SIZE);
    localparam logic BLANK_ONLY = (BLANK_WRITES_ONLY != 0);

    logic           is_pix;
    logic           wr_fire;
    logic           ram_we;

    logic [HSZ-1:0] pos_x_sh, pos_x_act;
    logic [VSZ-1:0] pos_y_sh, pos_y_act;
    logic           en_sh, en_act;

    logic           vsync_q;
    logic           vs_fall;

    logic [HSZ:0]   h_ext, px_ext, px_end;
    logic [VSZ:0]   v_ext, py_ext, py_end;
    logic           hit;
    logic [LW-1:0]  dx, dy;
    logic [AW-1:0]  rd_addr;
    logic [PIXEL_W-1:0] rd_data;
    pixel_t         rd_pix;

    logic           hit_q, de_q, hsync_q;

    // Host write handshake
    assign is_pix     = (wr_addr_i < 11'(NPIX));
    assign wr_ready_o = is_pix ? ~(BLANK_ONLY & de_i) : 1'b1;
    assign wr_fire    = wr_valid_i & wr_ready_o;
    assign ram_we     = wr_fire & is_pix;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pos_x_sh <= '0;
            pos_y_sh <= '0;
            en_sh    <= 1'b0;
        end else if (wr_fire) begin
            if (wr_addr_i == ADDR_POS_X) pos_x_sh <= wr_data_i[HSZ-1:0];
            if (wr_addr_i == ADDR_POS_Y) pos_y_sh <= wr_data_i[VSZ-1:0];
            if (wr_addr_i == ADDR_CTRL)  en_sh    <= wr_data_i[0];
        end
    end

    // vsync_q doubles as the first stage of the vsync delay line.
    assign vs_fall = vsync_q & ~vsync_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pos_x_act      <= '0;
            pos_y_act      <= '0;
            en_act         <= 1'b0;
            frame_commit_o <= 1'b0;
        end else begin
            frame_commit_o <= vs_fall;
            if (vs_fall) begin
                pos_x_act <= pos_x_sh;
                pos_y_act <= pos_y_sh;
                en_act    <= en_sh;
            end
        end
    end

    // Stage 1: hit test on widened operands so pos+SIZE never wraps.
    assign h_ext  = {1'b0, hcount_i};
    assign px_ext = {1'b0, pos_x_act};
    assign px_end = px_ext + (HSZ+1)'(SIZE);
    assign v_ext  = {1'b0, vcount_i};
    assign py_ext = {1'b0, pos_y_act};
    assign py_end = py_ext + (VSZ+1)'(SIZE);

    assign hit = en_act & de_i
               & (h_ext >= px_ext) & (h_ext < px_end)
               & (v_ext >= py_ext) & (v_ext < py_end);

    assign dx      = hcount_i[LW-1:0] - pos_x_act[LW-1:0];
    assign dy      = vcount_i[LW-1:0] - pos_y_act[LW-1:0];
    assign rd_addr = {dy, dx};

    sprite_ram #(
        .DEPTH (NPIX),
        .AW    (AW),
        .W     (PIXEL_W)
    ) u_ram (
        .clk_i   (clk_i),
        .wr_en   (ram_we),
        .wr_addr (wr_addr_i[AW-1:0]),
        .wr_data (wr_data_i),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hit_q   <= 1'b0;
            de_q    <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            hit_q   <= hit;
            de_q    <= de_i;
            hsync_q <= hsync_i;
            vsync_q <= vsync_i;
        end
    end

    // Stage 2: output mux, transparent black outside the sprite.
    assign rd_pix = unpack_pixel(rd_data);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fg_r_o     <= '0;
            fg_g_o     <= '0;
            fg_b_o     <= '0;
            fg_alpha_o <= '0;
            de_o       <= 1'b0;
            hsync_o    <= 1'b1;
            vsync_o    <= 1'b1;
        end else begin
            fg_r_o     <= hit_q ? rd_pix.r     : '0;
            fg_g_o     <= hit_q ? rd_pix.g     : '0;
            fg_b_o     <= hit_q ? rd_pix.b     : '0;
            fg_alpha_o <= hit_q ? rd_pix.alpha : '0;
            de_o       <= de_q;
            hsync_o    <= hsync_q;
            vsync_o    <= vsync_q;
        end
    end

endmodule

// File: tb/tb_sprite_layer.sv
// Scoreboard bench for sprite_layer: a reference model predicts each pixel's
// outputs when driven; the prediction is compared two cycles later.
module tb_sprite_layer;

    localparam int HSZ  = 10;
    localparam int VSZ  = 9;
    localparam int SIZE = 16;
    localparam int NPIX = SIZE * SIZE;

    logic           clk_i = 1'b0;
    logic           rstn_i = 1'b0;
    logic [HSZ-1:0] hcount_i = '0;
    logic [VSZ-1:0] vcount_i = '0;
    logic           de_i = 1'b0;
    logic           hsync_i = 1'b1;
    logic           vsync_i = 1'b1;
    logic           wr_valid_i = 1'b0;
    logic           wr_ready_o;
    logic [10:0]    wr_addr_i = '0;
    logic [14:0]    wr_data_i = '0;
    logic [3:0]     fg_r_o, fg_g_o, fg_b_o;
    logic [2:0]     fg_alpha_o;
    logic           de_o, hsync_o, vsync_o, frame_commit_o;

    sprite_layer #(
        .HSZ (HSZ), .VSZ (VSZ), .SIZE (SIZE), .BLANK_WRITES_ONLY (1)
    ) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .hcount_i       (hcount_i),
        .vcount_i       (vcount_i),
        .de_i           (de_i),
        .hsync_i        (hsync_i),
        .vsync_i        (vsync_i),
        .wr_valid_i     (wr_valid_i),
        .wr_ready_o     (wr_ready_o),
        .wr_addr_i      (wr_addr_i),
        .wr_data_i      (wr_data_i),
        .fg_r_o         (fg_r_o),
        .fg_g_o         (fg_g_o),
        .fg_b_o         (fg_b_o),
        .fg_alpha_o     (fg_alpha_o),
        .de_o           (de_o),
        .hsync_o        (hsync_o),
        .vsync_o        (vsync_o),
        .frame_commit_o (frame_commit_o)
    );

    always #20 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [14:0] m_ram [NPIX];
    int   sh_x = 0, sh_y = 0, act_x = 0, act_y = 0;
    bit   sh_en = 0, act_en = 0;
    bit   prev_vs = 1, fc_exp = 0;
    bit   accepted = 0;
    logic [17:0] sb_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        sh_x = 0; sh_y = 0; sh_en = 0;
        act_x = 0; act_y = 0; act_en = 0;
        prev_vs = 1; fc_exp = 0;
    endtask

    // One pixel clock: score the output due now, drive new inputs, predict.
    task automatic step(input int h, input int v, input bit de, input bit vs,
                        input bit wv, input int wa, input int wd);
        logic [17:0] e;
        bit rdy, hs, hit, fall;
        int idx;
        @(negedge clk_i);
        if (sb_q.size() >= 2) begin
            e = sb_q.pop_front();
            check_eq("pipe", {14'b0, de_o, hsync_o, vsync_o, fg_alpha_o, fg_r_o, fg_g_o, fg_b_o},
                     {14'b0, e});
        end
        check_eq("commit", {31'b0, frame_commit_o}, {31'b0, fc_exp});
        hs = ((h >> 2) & 1) != 0;
        hcount_i   = h[HSZ-1:0];
        vcount_i   = v[VSZ-1:0];
        de_i       = de;
        hsync_i    = hs;
        vsync_i    = vs;
        wr_valid_i = wv;
        wr_addr_i  = wa[10:0];
        wr_data_i  = wd[14:0];
        #1;
        rdy = (wa < NPIX) ? !de : 1'b1;
        if (wv) check_eq("ready", {31'b0, wr_ready_o}, {31'b0, rdy});
        hit = act_en && de && h >= act_x && h < act_x + SIZE && v >= act_y && v < act_y + SIZE;
        idx = hit ? (v - act_y) * SIZE + (h - act_x) : 0;
        e = {de, hs, vs, hit ? m_ram[idx] : 15'h0};
        sb_q.push_back(e);
        fall = prev_vs && !vs;
        fc_exp = fall;
        if (fall) begin
            act_x = sh_x; act_y = sh_y; act_en = sh_en;
        end
        prev_vs = vs;
        accepted = wv && rdy;
        if (accepted) begin
            if (wa < NPIX)        m_ram[wa] = wd[14:0];
            else if (wa == 'h400) sh_x = wd & 'h3FF;
            else if (wa == 'h401) sh_y = wd & 'h1FF;
            else if (wa == 'h402) sh_en = wd[0];
        end
    endtask

    task automatic blank(input int n);
        repeat (n) step(700, 500, 0, 1, 0, 0, 0);
    endtask

    task automatic vpulse();
        step(700, 500, 0, 0, 0, 0, 0);
        step(700, 500, 0, 0, 0, 0, 0);
        step(700, 500, 0, 1, 0, 0, 0);
        blank(2);
    endtask

    task automatic wr(input int a, input int d);
        int tries = 0;
        do begin
            step(700, 500, 0, 1, 1, a, d);
            tries++;
        end while (!accepted && tries < 8);
        if (!accepted) check_eq("wr_timeout", {31'b0, wr_ready_o}, 32'd1);
    endtask

    task automatic line(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) step(h, v, 1, 1, 0, 0, 0);
        blank(1);
    endtask

    task automatic hold_reset(input int cycles);
        @(negedge clk_i);
        de_i = 1'b1; hcount_i = 10'd300; vcount_i = 9'd50;
        hsync_i = 1'b1; vsync_i = 1'b1; wr_valid_i = 1'b0;
        rstn_i = 1'b0;
        #1;
        for (int i = 0; i < cycles; i++) begin
            check_eq("rst_fg", {20'b0, fg_alpha_o, fg_r_o, fg_g_o, fg_b_o}, 32'd0);
            check_eq("rst_de", {31'b0, de_o}, 32'd0);
            check_eq("rst_sync", {30'b0, hsync_o, vsync_o}, 32'd3);
            check_eq("rst_commit", {31'b0, frame_commit_o}, 32'd0);
            @(negedge clk_i);
            hcount_i = hcount_i + 10'd1;
            #1;
        end
        model_reset();
        rstn_i = 1'b1;
    endtask

    initial begin
        hold_reset(4);
        blank(3);

        // Basic draw
        for (int i = 0; i < NPIX; i++) wr(i, 'h6000 | i);
        wr('h400, 100);
        wr('h401, 50);
        wr('h402, 1);
        blank(2);
        line(50, 96, 120);
        vpulse();
        line(50, 96, 120);
        line(65, 96, 120);
        line(49, 98, 118);
        line(66, 98, 118);

        // Shadow timing: mid-frame register write is accepted during active video
        step(101, 51, 1, 1, 1, 'h400, 200);
        line(51, 96, 120);
        vpulse();
        line(52, 96, 104);
        line(52, 196, 220);

        // Register write on the exact vsync falling edge
        step(700, 500, 0, 0, 1, 'h400, 300);
        step(700, 500, 0, 1, 0, 0, 0);
        blank(2);
        line(53, 196, 220);
        line(53, 296, 304);
        vpulse();
        line(54, 196, 200);
        line(54, 296, 320);

        // Edge clip
        wr('h400, 632);
        wr('h401, 476);
        vpulse();
        line(476, 624, 639);
        line(476, 0, 9);
        line(479, 628, 639);
        line(0, 628, 639);
        line(3, 0, 9);
        line(475, 630, 639);

        // Write handshake
        wr('h400, 100);
        wr('h401, 50);
        vpulse();
        for (int h = 100; h <= 110; h++) step(h, 50, 1, 1, 1, 5, 'h7ABC);
        step(700, 500, 0, 1, 1, 5, 'h7ABC);
        step(101, 50, 1, 1, 1, 'h100, 'h1234);
        step(102, 50, 1, 1, 1, 'h403, 'h2345);
        line(50, 98, 110);

        // Disable
        wr('h402, 0);
        line(50, 100, 110);
        vpulse();
        line(50, 96, 120);

        // Mid-frame reset, then re-enable; RAM contents survive
        wr('h402, 1);
        vpulse();
        line(50, 100, 106);
        hold_reset(3);
        line(50, 100, 106);
        wr('h400, 100);
        wr('h401, 50);
        wr('h402, 1);
        vpulse();
        line(50, 100, 106);
        for (int i = 0; i < 6; i++) step(700, 500, i % 2, 1, 0, 0, 0);
        blank(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sprite_layer.md
Name: sprite_layer

Overview:
- Foreground source for the per-channel colour blenders: one SIZE x SIZE hardware sprite overlaid on the raster.
- Consumes the video timing counters and DE/sync.
- Produces 4-bit fg R/G/B, 3-bit fg alpha and DE/hsync/vsync, all delayed to the same latency.
- A host write port loads the sprite pixel RAM and the position/control registers. Position/control take effect only at frame boundaries, so there is no tearing.

Parameters:
- HSZ, 10, width of hcount_i (640-pixel line).
- VSZ, 9, width of vcount_i (480 lines).
- SIZE, 16, sprite edge in pixels; power of two, 4..32.
- BLANK_WRITES_ONLY, 1, when 1 pixel-RAM writes are accepted only while de_i=0.

Ports:
- clk_i  in  1  pixel clock (25 MHz).
- rstn_i  in  1  asynchronous reset, active-low.
- hcount_i  in  HSZ  current pixel x.
- vcount_i  in  VSZ  current line y.
- de_i  in  1  display enable.
- hsync_i  in  1  hsync, active-low.
- vsync_i  in  1  vsync, active-low.
- wr_valid_i  in  1  host write request.
- wr_ready_o  out  1  host write accepted this cycle when valid&ready.
- wr_addr_i  in  11  0x000..SIZE*SIZE-1 = pixel RAM; 0x400 = pos_x; 0x401 = pos_y; 0x402 = ctrl (bit0 enable).
- wr_data_i  in  15  pixel: {alpha[14:12], r[11:8], g[7:4], b[3:0]}; registers use low bits.
- fg_r_o  out  4  sprite red.
- fg_g_o  out  4  sprite green.
- fg_b_o  out  4  sprite blue.
- fg_alpha_o  out  3  sprite alpha, 0 = transparent.
- de_o  out  1  de_i delayed by 2.
- hsync_o  out  1  hsync_i delayed by 2.
- vsync_o  out  1  vsync_i delayed by 2.
- frame_commit_o  out  1  one-cycle pulse when shadow registers are copied to active.

Behaviour:
- Reset is asynchronous on rstn_i low:
  - All outputs 0, except hsync_o and vsync_o, which reset to 1 (inactive).
  - Shadow and active pos_x, pos_y and enable are cleared to 0.
  - Pixel RAM is not reset.
  - Deasserting reset mid-frame resumes at the next pixel, with no replay of lost writes.
- Pipeline latency is exactly 2 cycles for every output, including de/hsync/vsync.
  - Stage 1: hit test and RAM address formation; RAM read registered.
  - Stage 2: output mux.
- Hit test: hit = enable_act & de_i & (hcount_i >= pos_x) & (hcount_i < pos_x+SIZE) & (vcount_i >= pos_y) & (vcount_i < pos_y+SIZE).
  - Sums are computed at HSZ+1 / VSZ+1 bits so there is no wrap.
  - A sprite crossing the right or bottom edge is clipped; pos_x >= 640 gives no hit.
- RAM address = (vcount_i-pos_y)*SIZE + (hcount_i-pos_x), truncated to log2(SIZE*SIZE) bits.
- Output mux: hit (delayed) ? RAM word : all fg fields 0, including alpha 0.
- Write handshake:
  - wr_ready_o is combinational.
  - For the pixel region: wr_ready_o = ~(BLANK_WRITES_ONLY & de_i).
  - For register addresses: always 1.
  - Unmapped addresses are accepted and discarded.
  - Transfer occurs on valid&ready; data and address must be held while valid & ~ready.
- Register writes go to shadow registers only.
- Commit: on the vsync_i falling edge (1 -> 0, detected with one registered copy), active <= shadow and frame_commit_o pulses 1 cycle later.
- Write and commit in the same cycle: commit copies the pre-write shadow value; the new value commits on the next frame.
- RAM write and read of the same address in the same cycle: the read returns the old data (read-first).
- The RAM is a single write port plus a single read port, suitable for block RAM inference.

Decomposition:
- Shared package video_pkg holds:
  - HRES=640, VRES=480.
  - Register address constants ADDR_POS_X, ADDR_POS_Y, ADDR_CTRL.
  - Pixel field offsets for alpha/r/g/b.
- One sub-module, sprite_ram: SIZE*SIZE x 15 simple dual-port, registered read, read-first.

Test Plan:
- Reset: hold rstn_i=0 mid-line with de_i=1 -> all fg outputs 0, de_o=0, hsync_o=vsync_o=1; release -> de_o follows de_i exactly 2 cycles later.
- Basic draw:
  - Setup: fill RAM with word = 0x6000 | index, pos_x=100, pos_y=50, enable=1, then one vsync falling edge.
  - At hcount=100, vcount=50: 2 cycles later alpha=6, {r,g,b}=0x000.
  - At hcount=115, vcount=65: 2 cycles later alpha=6, {r,g,b}=0x0FF.
  - At hcount=99 or 116: alpha=0.
- Shadow timing:
  - Write pos_x=200 mid-frame -> sprite stays at x=100 until vsync falls; frame_commit_o pulses once; next frame the hit starts at hcount=200.
  - pos_x written in the exact cycle of the vsync falling edge -> commits one frame later.
- Edge clip: pos_x=632, pos_y=476 -> hits only for hcount 632..639 and vcount 476..479; no hits at hcount 0..7 or vcount 0..3 (no wrap).
- Write handshake, BLANK_WRITES_ONLY=1:
  - Pixel write with de_i=1 -> wr_ready_o=0 and RAM unchanged; write completes on the first de_i=0 cycle.
  - Register write with de_i=1 -> accepted immediately.
- Disable: ctrl=0 committed -> alpha=0 for the whole frame even where RAM alpha is 7.
